// File: rtl/boot_pkg.sv
// Shared definitions for the boot-time instruction loader: state encoding and
// default image placement, size and flash timeout.
package boot_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStream = 3'd1,
        StWrite  = 3'd2,
        StDone   = 3'd3,
        StError  = 3'd4
    } boot_state_e;

    localparam logic [23:0] DefaultFlashBase = 24'h002000;
    localparam int unsigned DefaultWordCount = 2048;
    localparam int unsigned DefaultTimeout   = 65535;
    localparam int unsigned BytesPerWord     = 4;

endpackage

// File: rtl/byte_packer.sv
// Collects flash bytes into a little-endian 32-bit word; the first byte lands
// in bits [7:0]. word_next_o already includes a byte being pushed this cycle.
module byte_packer
    import boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        push_i,
    input  logic [7:0]  byte_i,
    output logic [2:0]  byte_cnt_o,
    output logic        full_o,
    output logic [31:0] word_next_o
);

    logic [BytesPerWord-1:0][7:0] lanes_q, lanes_d;
    logic [2:0]                   cnt_q, cnt_d;

    assign full_o      = cnt_q[2];
    assign byte_cnt_o  = cnt_q;
    assign word_next_o = lanes_d;

    always_comb begin
        lanes_d = lanes_q;
        cnt_d   = cnt_q;
        if (clear_i) begin
            lanes_d = '0;
            cnt_d   = '0;
        end else if (push_i && !full_o) begin
            lanes_d[cnt_q[1:0]] = byte_i;
            cnt_d               = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lanes_q <= '0;
            cnt_q   <= '0;
        end else begin
            lanes_q <= lanes_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Streams a boot image from flash into instruction RAM word by word and holds
// the core in reset until the whole image has been written.
module instr_loader
    import boot_pkg::*;
#(
    parameter logic [23:0] FLASH_BASE = DefaultFlashBase,
    parameter int unsigned WORD_COUNT = DefaultWordCount,
    parameter int unsigned TIMEOUT    = DefaultTimeout,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        flash_req_o,
    output logic [23:0] flash_addr_o,
    input  logic [7:0]  flash_byte_i,
    input  logic        flash_valid_i,
    output logic        flash_ready_o,
    output logic        mem_write_o,
    output logic [12:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        core_rst_no
);

    localparam logic [10:0] LastWord  = 11'(WORD_COUNT - 1);
    localparam logic [15:0] IdleLimit = 16'(TIMEOUT - 1);

    boot_state_e state_q, state_d;
    logic [10:0] word_cnt_q, word_cnt_d;
    logic [15:0] idle_q, idle_d;
    logic        pack_clear, accept, full;
    logic [2:0]  byte_cnt;
    logic [31:0] word_next;

    logic        flash_req_q, mem_write_q, busy_q, done_q, error_q, core_rst_q;
    logic [23:0] flash_addr_q;
    logic [12:0] mem_addr_q;
    logic [31:0] mem_data_q;

    assign flash_ready_o = (state_q == StStream) && !full;
    assign accept        = flash_ready_o && flash_valid_i;

    byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (pack_clear),
        .push_i      (accept),
        .byte_i      (flash_byte_i),
        .byte_cnt_o  (byte_cnt),
        .full_o      (full),
        .word_next_o (word_next)
    );

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        idle_d     = idle_q;
        pack_clear = 1'b0;
        case (state_q)
            StIdle: if (AUTO_START || start_i) state_d = StStream;
            StStream: begin
                if (accept) begin
                    idle_d = '0;
                    if (byte_cnt == 3'd3) state_d = StWrite;
                end else if (idle_q == IdleLimit) begin
                    state_d = StError;
                end else begin
                    idle_d = idle_q + 16'd1;
                end
            end
            StWrite: begin
                word_cnt_d = word_cnt_q + 11'd1;
                idle_d     = '0;
                pack_clear = 1'b1;
                state_d    = (word_cnt_q == LastWord) ? StDone : StStream;
            end
            StDone: state_d = StDone;
            StError: begin
                if (start_i) begin
                    state_d    = StStream;
                    word_cnt_d = '0;
                    idle_d     = '0;
                    pack_clear = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            word_cnt_q   <= '0;
            idle_q       <= '0;
            flash_req_q  <= 1'b0;
            flash_addr_q <= '0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            core_rst_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            idle_q       <= idle_d;
            flash_addr_q <= FLASH_BASE;
            flash_req_q  <= (state_d == StStream) || (state_d == StWrite);
            busy_q       <= (state_d == StStream) || (state_d == StWrite);
            mem_write_q  <= (state_d == StWrite);
            if (state_d == StWrite) begin
                mem_addr_q <= {word_cnt_q, 2'b00};
                mem_data_q <= word_next;
            end
            done_q       <= (state_d == StDone);
            core_rst_q   <= (state_d == StDone);
            error_q      <= (state_d == StError);
        end
    end

    assign flash_req_o  = flash_req_q;
    assign flash_addr_o = flash_addr_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign core_rst_no  = core_rst_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: auto-start instance (u_a) and start_i-driven
// instance (u_b), both with a 4-word image and a 16-cycle flash timeout.
module tb_instr_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n[2], start[2], valid[2];
    logic [7:0]  fbyte[2];
    logic        req[2], ready[2], mem_write[2], busy[2], done[2], error[2], core_rst_n[2];
    logic [23:0] faddr[2];
    logic [12:0] maddr[2];
    logic [31:0] mdata[2];

    int tests = 0;
    int fails = 0;
    logic [44:0] wlog0[$];
    logic [44:0] wlog1[$];

    // Per word: byte stream in arrival order (first byte in [31:24]), expected write.
    typedef struct {
        logic [31:0] stream;
        logic [12:0] addr;
        logic [31:0] data;
    } vec_t;
    vec_t vec[4];

    instr_loader #(.WORD_COUNT(4), .TIMEOUT(16), .AUTO_START(1'b1)) u_a (
        .clk_i(clk), .rst_ni(rst_n[0]), .start_i(start[0]),
        .flash_req_o(req[0]), .flash_addr_o(faddr[0]), .flash_byte_i(fbyte[0]),
        .flash_valid_i(valid[0]), .flash_ready_o(ready[0]), .mem_write_o(mem_write[0]),
        .mem_addr_o(maddr[0]), .mem_data_o(mdata[0]), .busy_o(busy[0]), .done_o(done[0]),
        .error_o(error[0]), .core_rst_no(core_rst_n[0])
    );

    instr_loader #(.WORD_COUNT(4), .TIMEOUT(16), .AUTO_START(1'b0)) u_b (
        .clk_i(clk), .rst_ni(rst_n[1]), .start_i(start[1]),
        .flash_req_o(req[1]), .flash_addr_o(faddr[1]), .flash_byte_i(fbyte[1]),
        .flash_valid_i(valid[1]), .flash_ready_o(ready[1]), .mem_write_o(mem_write[1]),
        .mem_addr_o(maddr[1]), .mem_data_o(mdata[1]), .busy_o(busy[1]), .done_o(done[1]),
        .error_o(error[1]), .core_rst_no(core_rst_n[1])
    );

    // Write monitor samples just after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (mem_write[0] === 1'b1) wlog0.push_back({maddr[0], mdata[0]});
        if (mem_write[1] === 1'b1) wlog1.push_back({maddr[1], mdata[1]});
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] stream_byte(input int v);
        logic [31:0] s;
        s = vec[v / 4].stream;
        return s[8 * (3 - (v % 4)) +: 8];
    endfunction

    task automatic feed(input int d, input int first, input int last, input bit toggle);
        int v = first;
        int cyc = 0;
        while (v < last && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (toggle && (cyc % 2 == 0)) begin
                valid[d] = 1'b0;
            end else begin
                valid[d] = 1'b1;
                fbyte[d] = stream_byte(v);
                if (ready[d] === 1'b1) v++;
            end
        end
        @(negedge clk);
        valid[d] = 1'b0;
        check("feed progress", 64'(v), 64'(last));
    endtask

    task automatic wait_done(input int d, input string name);
        int cyc = 0;
        while (done[d] !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 64'(done[d]), 64'd1);
    endtask

    task automatic clear_log(input int d);
        if (d == 0) wlog0.delete();
        else wlog1.delete();
    endtask

    task automatic check_writes(input int d, input int n, input string name);
        logic [44:0] q[$];
        if (d == 0) q = wlog0;
        else q = wlog1;
        check({name, " write count"}, 64'(q.size()), 64'(n));
        for (int i = 0; i < n && i < q.size(); i++)
            check($sformatf("%s write %0d", name, i), 64'(q[i]), 64'({vec[i].addr, vec[i].data}));
    endtask

    task automatic check_reset_outputs(input int d, input string name);
        check({name, " ctrl"}, 64'({req[d], ready[d], mem_write[d], busy[d], done[d],
                                   error[d], core_rst_n[d]}), 64'd0);
        check({name, " flash_addr"}, 64'(faddr[d]), 64'd0);
        check({name, " mem bus"}, 64'({maddr[d], mdata[d]}), 64'd0);
    endtask

    task automatic do_reset(input int d);
        @(negedge clk);
        rst_n[d] = 1'b0;
        start[d] = 1'b0;
        valid[d] = 1'b0;
        repeat (2) @(negedge clk);
        clear_log(d);
        rst_n[d] = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input int d);
        @(negedge clk);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
    endtask

    initial begin
        vec[0] = '{stream: 32'h00010203, addr: 13'h000, data: 32'h03020100};
        vec[1] = '{stream: 32'h04050607, addr: 13'h004, data: 32'h07060504};
        vec[2] = '{stream: 32'h08090A0B, addr: 13'h008, data: 32'h0B0A0908};
        vec[3] = '{stream: 32'h0C0D0E0F, addr: 13'h00C, data: 32'h0F0E0D0C};

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b1;
            start[d] = 1'b0;
            valid[d] = 1'b0;
            fbyte[d] = 8'h00;
        end
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "reset a");
        check_reset_outputs(1, "reset b");

        // Full load at one byte per cycle.
        clear_log(0);
        rst_n[0] = 1'b1;
        @(negedge clk);
        check("autostart busy", 64'(busy[0]), 64'd1);
        check("autostart req", 64'(req[0]), 64'd1);
        check("flash_addr", 64'(faddr[0]), 64'h002000);
        check("core held during load", 64'(core_rst_n[0]), 64'd0);
        feed(0, 0, 16, 1'b0);
        wait_done(0, "full load done");
        check_writes(0, 4, "full");
        check("full core_rst_n", 64'(core_rst_n[0]), 64'd1);
        check("full idle flags", 64'({busy[0], req[0], error[0]}), 64'd0);

        // Back-pressure: valid every other cycle.
        do_reset(0);
        feed(0, 0, 16, 1'b1);
        wait_done(0, "backpressure done");
        check_writes(0, 4, "backpressure");

        // Timeout after 5 bytes, then restart from ERROR.
        do_reset(0);
        feed(0, 0, 5, 1'b0);
        repeat (15) @(negedge clk);
        check("no error at idle 16", 64'(error[0]), 64'd0);
        check("busy at idle 16", 64'(busy[0]), 64'd1);
        @(negedge clk);
        check("error at idle 17", 64'(error[0]), 64'd1);
        check("error state flags", 64'({busy[0], req[0], core_rst_n[0], done[0]}), 64'd0);
        check_writes(0, 1, "timeout");
        clear_log(0);
        pulse_start(0);
        check("restart busy", 64'(busy[0]), 64'd1);
        feed(0, 0, 16, 1'b0);
        wait_done(0, "restart done");
        check_writes(0, 4, "restart");
        check("restart error clear", 64'(error[0]), 64'd0);

        // Reset in the middle of word 2.
        do_reset(0);
        feed(0, 0, 9, 1'b0);
        check("midreset writes before", 64'(wlog0.size()), 64'd2);
        rst_n[0] = 1'b0;
        #1;
        check_reset_outputs(0, "midreset");
        repeat (3) @(negedge clk);
        check("midreset no strobe", 64'(wlog0.size()), 64'd2);
        clear_log(0);
        rst_n[0] = 1'b1;
        feed(0, 0, 16, 1'b0);
        wait_done(0, "midreset reload done");
        check_writes(0, 4, "midreset reload");

        // AUTO_START=0: start needed; start ignored in STREAM and DONE.
        rst_n[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("no autostart", 64'({busy[1], req[1]}), 64'd0);
        pulse_start(1);
        check("start busy", 64'(busy[1]), 64'd1);
        feed(1, 0, 6, 1'b0);
        pulse_start(1);
        check("start in stream ignored", 64'(busy[1]), 64'd1);
        feed(1, 6, 16, 1'b0);
        wait_done(1, "ignored start done");
        check_writes(1, 4, "ignored start");
        pulse_start(1);
        repeat (10) @(negedge clk);
        check("done held", 64'({done[1], core_rst_n[1], busy[1]}), 64'b110);
        check_writes(1, 4, "after done start");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- FLASH_BASE, 24'h002000, flash byte address of first image byte.
- WORD_COUNT, 2048, number of 32-bit words loaded.
- TIMEOUT, 65535, maximum idle cycles waiting for a flash byte.
- AUTO_START, 1, when 1, load begins without start_i.

REQ-002 SHALL provide ports, one per line: name, direction, width, meaning.
- clk_i, in, 1, sole clock.
- rst_ni, in, 1, asynchronous active-low reset.
- start_i, in, 1, single-cycle load request.
- flash_req_o, out, 1, flash read stream request, held for the whole stream.
- flash_addr_o, out, 24, stream start address, equals FLASH_BASE.
- flash_byte_i, in, 8, stream byte.
- flash_valid_i, in, 1, byte valid.
- flash_ready_o, out, 1, byte accepted when valid and ready are both high.
- mem_write_o, out, 1, instruction-RAM write strobe.
- mem_addr_o, out, 13, instruction-RAM byte address; bits [1:0] are always 0.
- mem_data_o, out, 32, instruction-RAM write word.
- busy_o, out, 1, load in progress.
- done_o, out, 1, load completed.
- error_o, out, 1, load aborted on timeout.
- core_rst_no, out, 1, active-low core reset; released only after a successful load.

REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, STREAM, WRITE, DONE and ERROR.
REQ-005 IDLE: SHALL go to STREAM on start_i, or on the first cycle after reset when AUTO_START=1.
REQ-006 STREAM: flash_req_o=1; flash_ready_o=1 while byte_cnt<4; each accepted byte SHALL be stored in lane byte_cnt, and byte_cnt SHALL increment.
REQ-007 Byte packing SHALL be little-endian: word = {b3,b2,b1,b0}, with b0 the first byte received.
REQ-008 When the 4th byte is accepted, the FSM SHALL go to WRITE in the next cycle.
REQ-009 WRITE: lasts exactly 1 cycle, with mem_write_o=1, mem_data_o=packed word, mem_addr_o={word_cnt[10:0],2'b00}, flash_ready_o=0.
REQ-010 After WRITE: word_cnt SHALL increment and byte_cnt SHALL clear; the FSM SHALL go to DONE if word_cnt==WORD_COUNT-1, otherwise back to STREAM.
REQ-011 DONE: flash_req_o=0, done_o=1, core_rst_no=1; the FSM SHALL stay in DONE until reset, and start_i SHALL be ignored.
REQ-012 STREAM timeout: an idle counter SHALL clear on each accepted byte; on reaching TIMEOUT, the FSM SHALL go to ERROR.
REQ-013 ERROR: error_o=1, flash_req_o=0, core_rst_no=0; the FSM SHALL stay in ERROR until start_i, which clears all counters and re-enters STREAM.
REQ-014 busy_o SHALL be 1 exactly in STREAM and WRITE.
REQ-015 mem_write_o SHALL never be high outside WRITE; mem_addr_o and mem_data_o hold their last values otherwise.
REQ-016 start_i SHALL be ignored in STREAM and WRITE.
REQ-017 flash_addr_o SHALL be constant FLASH_BASE.
REQ-018 flash_valid_i while flash_ready_o=0 SHALL NOT be consumed.

Reset
REQ-019 Reset SHALL put the FSM in IDLE with all counters and the data register at 0.
REQ-020 During reset, all outputs SHALL be 0, including core_rst_no=0, which holds the core in reset.
REQ-021 Reset asserted mid-load SHALL abort immediately with no further write strobe; a new load then starts from word 0.

Structure
REQ-022 A shared package boot_pkg SHALL hold the state encoding and the default FLASH_BASE, WORD_COUNT and TIMEOUT constants.
REQ-023 Byte-to-word packing (lane register, byte_cnt, full flag) SHALL be a sub-module, byte_packer.
REQ-024 word_cnt SHALL be 11 bits wide, and the idle counter SHALL be 16 bits wide.

Verification
REQ-025 Scenario, full load: AUTO_START=1, WORD_COUNT=4, bytes 00..0F at one per cycle.
- Required: writes 32'h03020100@0x000, 32'h07060504@0x004, 32'h0B0A0908@0x008, 32'h0F0E0D0C@0x00C.
- Then done_o=1 and core_rst_no=1.

REQ-026 Scenario, back-pressure: flash_valid_i toggles every other cycle.
- Required: same data and addresses as REQ-025.
- Exactly one mem_write_o cycle per word.

REQ-027 Scenario, timeout: TIMEOUT=16, stream stops after 5 bytes.
- Required: error_o=1 on the 17th idle cycle, with exactly one write at 0x000.
- Then start_i restarts the load at word 0.

REQ-028 Scenario, mid-load reset: rst_ni low during word 2.
- Required: all outputs 0 immediately.
- After release, the first write is at 0x000.

REQ-029 Scenario, ignored start: AUTO_START=0, start_i pulsed during STREAM and during DONE.
- Required: no restart and no extra writes; word count is unchanged.
